aurora_tx_framer: RTL
=====================

// Module: aurora_tx_framer
// PURPOSE
//  Builds Aurora 64b66b TX frames from a 32-bit sample stream. Runs in the Aurora user_clk domain.
//  Drives the 128-bit AXIS TX port of the Aurora wrapper: one header beat, then payload packed 4 samples/beat.
//  Source end of the upstream link; replaces the RX->TX loopback as the TX traffic source.
// PARAMETERS
//  LEN_W      16   width of frame_len and of the header length field (fixed 16 in header)
//  SEQ_W      16   width of frame sequence counter (fixed 16 in header)
// PORTS
//  user_clk     in   1    Aurora user clock; all logic on rising edge
//  rst_n        in   1    synchronous reset, active-low
//  channel_up   in   1    Aurora channel status; gates frame start
//  frame_len    in   LEN_W  payload length in samples, sampled at frame start
//  s_tdata      in   32   input sample
//  s_tvalid     in   1    input sample valid
//  s_tready     out  1    input sample accepted
//  tx_tdata     out  128  AXIS TX data to Aurora
//  tx_tkeep     out  16   AXIS TX byte enables
//  tx_tvalid    out  1    AXIS TX valid
//  tx_tlast     out  1    AXIS TX end of frame
//  tx_tready    in   1    AXIS TX ready from Aurora
//  busy         out  1    frame in progress (state != IDLE)
// BEHAVIOUR
//  Reset: tx_tvalid/tx_tlast/s_tready/busy=0, tx_tdata=0, tx_tkeep=0, seq=0, lane=0, state=IDLE.
//  FSM IDLE -> HDR -> PAYLOAD -> IDLE.
//   IDLE: if channel_up && s_tvalid && out_free: latch len=frame_len, go HDR. channel_up checked only here.
//   HDR: load header beat into output reg: [127:112]=16'hA55A, [111:96]=seq, [95:80]=len, [79:0]=0;
//        tkeep=16'hFFFF; tlast=(len==0). len==0 -> IDLE, else -> PAYLOAD. seq+1 on load, wraps FFFF->0000.
//   PAYLOAD: sample k of beat at [32k+31:32k], k=0..3 (first sample at LSB). remaining counts down from len.
//        Beat closes on 4th sample or on final sample (remaining==1); closing sample merged combinationally
//        with accumulator into output reg same cycle -> tx_tvalid next cycle. Final beat: tlast=1,
//        tkeep=4 bytes per valid sample from LSB (1->000F,2->00FF,3->0FFF,4->FFFF), unused data bytes=0. -> IDLE.
//  out_free = !tx_tvalid || tx_tready.
//  s_tready = (state==PAYLOAD) && ((lane!=3 && remaining!=1) || out_free); sustained 1 sample/cycle at tready=1.
//  AXIS rules: tx_tdata/tkeep/tlast stable while tx_tvalid && !tx_tready; tx_tvalid never drops without handshake.
//  Back-to-back frames: IDLE may start next frame the cycle after final beat loads; no bubble beyond HDR cycle.
//  channel_up falling mid-frame: frame continues, stalls on tx_tready; no abort.
//  frame_len changes mid-frame: ignored until next IDLE.
//  rst_n low mid-frame: all state cleared next edge; partial frame discarded, tx_tvalid=0 immediately after.
// CONFIGURATION
//  AURORA_TX_FRAMER_STATS_EN defined: adds outputs stat_frames[31:0] (+1 per tlast handshake),
//   stat_beats[31:0] (+1 per tx handshake), stat_stalls[31:0] (+1 per cycle tx_tvalid && !tx_tready);
//   all saturate at FFFF_FFFF, clear on rst_n. Undefined: ports and logic absent.
// STRUCTURE
//  Package aurora_framer_pkg: HDR_MAGIC=16'hA55A, header field offsets, SAMPLES_PER_BEAT=4,
//   typedef enum logic [1:0] {IDLE,HDR,PAYLOAD} framer_state_t, function keep_from_count().
//  Sub-module aurora_tx_framer_stats (three saturating counters), instantiated only under STATS_EN.
// TESTING
//  1 len=8, samples 1..8, tready=1 -> beats A55A_0000_0008_0..0 / {4,3,2,1} / {8,7,6,5}, tkeep FFFF, tlast beat 3.
//  2 len=5, samples 1..5 -> 3rd beat data=0..0_00000005, tkeep=000F, tlast=1.
//  3 len=0 -> single header beat, tkeep=FFFF, tlast=1, no sample consumed; seq increments.
//  4 len=37, random tready (50%) and s_tvalid gaps -> beats stable under stall, all 37 samples in order, 11 beats.
//  5 channel_up=0 with s_tvalid=1 -> no tx_tvalid for 100 cycles; channel_up=1 -> header within 2 cycles.
//  6 65537 len=0 frames -> seq 0000..FFFF then 0000; rst_n low mid-payload -> tx_tvalid=0, busy=0, next seq=0000.

Source files
------------

// File: rtl/aurora_framer_pkg.sv
// rtl/aurora_framer_pkg.sv - shared constants, state type and keep helper for the Aurora TX framer
package aurora_framer_pkg;

  localparam logic [15:0] HDR_MAGIC        = 16'hA55A;
  localparam int          HDR_MAGIC_LSB    = 112;
  localparam int          HDR_SEQ_LSB      = 96;
  localparam int          HDR_LEN_LSB      = 80;
  localparam int          SAMPLES_PER_BEAT = 4;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } framer_state_t;

  // Byte enables for a beat carrying 'count' 32-bit samples packed from the LSB.
  function automatic logic [15:0] keep_from_count(input logic [2:0] count);
    logic [15:0] keep;
    case (count)
      3'd1:    keep = 16'h000F;
      3'd2:    keep = 16'h00FF;
      3'd3:    keep = 16'h0FFF;
      3'd4:    keep = 16'hFFFF;
      default: keep = 16'h0000;
    endcase
    return keep;
  endfunction

endpackage

// File: rtl/aurora_tx_framer_stats.sv
// rtl/aurora_tx_framer_stats.sv - saturating frame/beat/stall counters on the framer TX port
module aurora_tx_framer_stats (
  input  logic        user_clk,
  input  logic        rst_n,
  input  logic        tx_tvalid,
  input  logic        tx_tready,
  input  logic        tx_tlast,
  output logic [31:0] stat_frames,
  output logic [31:0] stat_beats,
  output logic [31:0] stat_stalls
);

  logic handshake;

  assign handshake = tx_tvalid && tx_tready;

  // Count handshakes, final beats and stalled cycles, holding at all-ones.
  always_ff @(posedge user_clk) begin
    if (!rst_n) begin
      stat_frames <= '0;
      stat_beats  <= '0;
      stat_stalls <= '0;
    end else begin
      if (handshake && !(&stat_beats)) begin
        stat_beats <= stat_beats + 32'd1;
      end
      if (handshake && tx_tlast && !(&stat_frames)) begin
        stat_frames <= stat_frames + 32'd1;
      end
      if (tx_tvalid && !tx_tready && !(&stat_stalls)) begin
        stat_stalls <= stat_stalls + 32'd1;
      end
    end
  end

endmodule

// File: rtl/aurora_tx_framer.sv
// rtl/aurora_tx_framer.sv - header + 4-samples-per-beat payload framer for the Aurora 64b66b TX port (option: AURORA_TX_FRAMER_STATS_EN)
module aurora_tx_framer
  import aurora_framer_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int SEQ_W = 16
) (
  input  logic             user_clk,
  input  logic             rst_n,
  input  logic             channel_up,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [31:0]      s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [127:0]     tx_tdata,
  output logic [15:0]      tx_tkeep,
  output logic             tx_tvalid,
  output logic             tx_tlast,
  input  logic             tx_tready,
  output logic             busy
`ifdef AURORA_TX_FRAMER_STATS_EN
  ,
  output logic [31:0]      stat_frames,
  output logic [31:0]      stat_beats,
  output logic [31:0]      stat_stalls
`endif
);

  framer_state_t   state;
  framer_state_t   state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] remaining;
  logic [SEQ_W-1:0] seq;
  logic [1:0]       lane;
  logic [2:0][31:0] acc;
  logic [127:0]     merged;
  logic [127:0]     hdr_beat;
  logic             out_free;
  logic             start;
  logic             accept;
  logic             last_sample;
  logic             closing;

  // The output register can take a new beat when it is empty or draining this cycle.
  assign out_free    = !tx_tvalid || tx_tready;
  assign start       = channel_up && s_tvalid && out_free;
  assign accept      = s_tvalid && s_tready;
  assign last_sample = (remaining == LEN_W'(1));
  assign closing     = (lane == 2'(SAMPLES_PER_BEAT - 1)) || last_sample;

  // State register.
  always_ff @(posedge user_clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a frame only starts with the link up and an output slot free.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = HDR;
      HDR:     state_nxt = (len_q == '0) ? IDLE : PAYLOAD;
      PAYLOAD: if (accept && last_sample) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: the beat-closing sample is only taken when the output register can accept it.
  always_comb begin
    busy     = (state != IDLE);
    s_tready = 1'b0;
    if (state == PAYLOAD) begin
      s_tready = ((lane != 2'(SAMPLES_PER_BEAT - 1)) && !last_sample) || out_free;
    end
  end

  // Header beat: magic, sequence number and length, rest zero.
  always_comb begin
    hdr_beat = '0;
    hdr_beat[HDR_MAGIC_LSB +: 16] = HDR_MAGIC;
    hdr_beat[HDR_SEQ_LSB   +: 16] = 16'(seq);
    hdr_beat[HDR_LEN_LSB   +: 16] = 16'(len_q);
  end

  // Closing beat: held samples below the current lane, incoming sample in it, zeros above.
  always_comb begin
    merged          = '0;
    merged[31:0]    = (lane == 2'd0) ? s_tdata : acc[0];
    merged[63:32]   = (lane == 2'd1) ? s_tdata : ((lane > 2'd1) ? acc[1] : 32'd0);
    merged[95:64]   = (lane == 2'd2) ? s_tdata : ((lane > 2'd2) ? acc[2] : 32'd0);
    merged[127:96]  = (lane == 2'd3) ? s_tdata : 32'd0;
  end

  // Datapath: length latch, sample accumulation, output beat register and sequence counter.
  always_ff @(posedge user_clk) begin
    if (!rst_n) begin
      len_q     <= '0;
      remaining <= '0;
      seq       <= '0;
      lane      <= '0;
      acc       <= '0;
      tx_tdata  <= '0;
      tx_tkeep  <= '0;
      tx_tvalid <= 1'b0;
      tx_tlast  <= 1'b0;
    end else begin
      if (tx_tvalid && tx_tready) begin
        tx_tvalid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= frame_len;
          end
        end
        HDR: begin
          // Entry into HDR required a free slot, so the register is empty here.
          tx_tdata  <= hdr_beat;
          tx_tkeep  <= 16'hFFFF;
          tx_tlast  <= (len_q == '0);
          tx_tvalid <= 1'b1;
          seq       <= seq + SEQ_W'(1);
          remaining <= len_q;
          lane      <= '0;
        end
        PAYLOAD: begin
          if (accept) begin
            remaining <= remaining - LEN_W'(1);
            if (closing) begin
              tx_tdata  <= merged;
              tx_tkeep  <= keep_from_count({1'b0, lane} + 3'd1);
              tx_tlast  <= last_sample;
              tx_tvalid <= 1'b1;
              lane      <= '0;
            end else begin
              case (lane)
                2'd0:    acc[0] <= s_tdata;
                2'd1:    acc[1] <= s_tdata;
                default: acc[2] <= s_tdata;
              endcase
              lane <= lane + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AURORA_TX_FRAMER_STATS_EN
  aurora_tx_framer_stats u_stats (
    .user_clk    (user_clk),
    .rst_n       (rst_n),
    .tx_tvalid   (tx_tvalid),
    .tx_tready   (tx_tready),
    .tx_tlast    (tx_tlast),
    .stat_frames (stat_frames),
    .stat_beats  (stat_beats),
    .stat_stalls (stat_stalls)
  );
`endif

endmodule
